slice_compare_seq: RTL and testbench

SLICE_COMPARE_SEQ -- requirements
Module: slice_compare_seq

---
 rtl/slice_compare_seq_pkg.sv | 19 +
 rtl/slice_compare_seq_if.sv | 28 ++
 rtl/slice_compare_seq_slice_cmp.sv | 23 ++
 rtl/slice_compare_seq.sv | 143 ++++++++++++++
 tb/tb_slice_compare_seq.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/slice_compare_seq_pkg.sv
// Shared types for the sequential slice comparator.
// Holds the FSM state encoding and the per-slice compare result type.
// No ports; imported by the interface users, the top and the slice comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Result of comparing one SLICE-bit chunk, A relative to B.
  typedef enum logic [1:0] {
    LT = 2'b00,
    EQ = 2'b01,
    GT = 2'b10
  } slice_res_t;

endpackage

// File: rtl/slice_compare_seq_if.sv
// Request/result bundle between a requester and the sequential comparator.
// master drives start/a/b/signed_mode and observes busy/done/agreat/bgreat/equal.
// slave is the comparator side: samples the request, drives the result flags.
interface slice_compare_seq_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             agreat;
  logic             bgreat;
  logic             equal;

  modport master (
    output start, a, b, signed_mode,
    input  busy, done, agreat, bgreat, equal
  );

  modport slave (
    input  start, a, b, signed_mode,
    output busy, done, agreat, bgreat, equal
  );

endinterface

// File: rtl/slice_compare_seq_slice_cmp.sv
// Combinational unsigned compare of one SLICE-bit chunk.
// Ports: a_i, b_i (SLICE bits each) -> res_o (LT/EQ/GT of a_i versus b_i).
// Zero latency; no handshake.
module slice_cmp
  import cmp_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output slice_res_t       res_o
);

  always_comb begin
    res_o = EQ;
    if (a_i > b_i) begin
      res_o = GT;
    end else if (a_i < b_i) begin
      res_o = LT;
    end
  end

endmodule

// File: rtl/slice_compare_seq.sv
// Sequential magnitude comparator: one SLICE-bit chunk per cycle, MSB slice first,
// stopping at the first differing slice. Ports: clk, rst_n, bus (slave side).
// Latency d+1 cycles from accept (d = slices examined); start ignored while busy.
module slice_compare_seq
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  slice_compare_seq_if.slave   bus
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] TOP_IDX = IDXW'(NSLICE - 1);

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  logic             agreat_q, agreat_d;
  logic             bgreat_q, bgreat_d;
  logic             equal_q, equal_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [SLICE-1:0] sl_a, sl_b;
  slice_res_t       sl_res;

  // Current slice of the captured operands. In signed mode the sign bit is
  // flipped on the top slice so two's-complement order becomes plain unsigned
  // (offset-binary) order; lower slices compare identically either way.
  always_comb begin
    sl_a = a_q[int'(idx_q) * SLICE +: SLICE];
    sl_b = b_q[int'(idx_q) * SLICE +: SLICE];
    if (sm_q && (idx_q == TOP_IDX)) begin
      sl_a[SLICE-1] = ~sl_a[SLICE-1];
      sl_b[SLICE-1] = ~sl_b[SLICE-1];
    end
  end

  slice_cmp #(
    .SLICE (SLICE)
  ) u_slice_cmp (
    .a_i   (sl_a),
    .b_i   (sl_b),
    .res_o (sl_res)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sm_d     = sm_q;
    agreat_d = agreat_q;
    bgreat_d = bgreat_q;
    equal_d  = equal_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_d      = bus.a;
          b_d      = bus.b;
          sm_d     = bus.signed_mode;
          idx_d    = TOP_IDX;
          agreat_d = 1'b0;
          bgreat_d = 1'b0;
          equal_d  = 1'b0;
        end
      end
      RUN: begin
        case (sl_res)
          GT: begin
            agreat_d = 1'b1;
            state_d  = DONE;
          end
          LT: begin
            bgreat_d = 1'b1;
            state_d  = DONE;
          end
          default: begin
            // Slice equal: either the last slice settles equality, or move down.
            if (idx_q == '0) begin
              equal_d = 1'b1;
              state_d = DONE;
            end else begin
              idx_d = idx_q - 1'b1;
            end
          end
        endcase
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state so every output
    // comes straight from a flop.
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sm_q     <= 1'b0;
      agreat_q <= 1'b0;
      bgreat_q <= 1'b0;
      equal_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sm_q     <= sm_d;
      agreat_q <= agreat_d;
      bgreat_q <= bgreat_d;
      equal_q  <= equal_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.agreat = agreat_q;
  assign bus.bgreat = bgreat_q;
  assign bus.equal  = equal_q;

endmodule

// File: tb/tb_slice_compare_seq.sv
// Self-checking bench for slice_compare_seq (WIDTH=16, SLICE=4).
// Drives the interface master side; expected results come from a signed/unsigned
// arithmetic model and a latency rule based on the highest differing bit.
module tb_slice_compare_seq;

  localparam int WIDTH  = 16;
  localparam int SLICE  = 4;
  localparam int NSLICE = WIDTH / SLICE;

  logic clk;
  logic rst_n;
  int   pass_cnt;
  int   total_cnt;

  slice_compare_seq_if #(.WIDTH(WIDTH)) bus ();

  slice_compare_seq #(
    .WIDTH (WIDTH),
    .SLICE (SLICE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: plain arithmetic compare, latency from the top differing slice.
  function automatic void model(input logic [15:0] av, input logic [15:0] bv,
                                input logic sm, output logic [2:0] flags,
                                output int lat);
    logic [15:0] diff;
    int          top;
    logic        ag, bg, eq;
    if (sm) begin
      ag = $signed(av) > $signed(bv);
      bg = $signed(av) < $signed(bv);
    end else begin
      ag = av > bv;
      bg = av < bv;
    end
    eq    = (av == bv);
    flags = {ag, bg, eq};
    diff  = av ^ bv;
    top   = -1;
    for (int i = 0; i < 16; i++) if (diff[i]) top = i;
    if (top < 0) lat = NSLICE + 1;
    else         lat = (NSLICE - top / SLICE) + 1;
  endfunction

  // Present a request so it is accepted on the next rising edge.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.a           = av;
    bus.b           = bv;
    bus.signed_mode = sm;
    @(posedge clk);
  endtask

  // Count cycles to done after the accept edge; scrambles inputs after capture.
  // Returns -1 if done never arrives within the budget.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) lat = k;
      if (k == 1) begin
        bus.start       = 1'b0;
        bus.a           = 16'($urandom);
        bus.b           = 16'($urandom);
        bus.signed_mode = 1'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.a = 16'h1111;
    bus.b = 16'h2222;
    bus.signed_mode = 1'b0;
    repeat (3) @(negedge clk);
    total_cnt++;
    if ({bus.busy, bus.done} !== 2'b00) $display("FAIL reset_busy_done: got %b want 00", {bus.busy, bus.done});
    else pass_cnt++;
    total_cnt++;
    if ({bus.agreat, bus.bgreat, bus.equal} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {bus.agreat, bus.bgreat, bus.equal});
    else pass_cnt++;
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL reset_release_idle: busy=%b want 0", bus.busy);
    else pass_cnt++;
  endtask

  task automatic test_directed;
    logic [15:0] va[6];
    logic [15:0] vb[6];
    logic        vs[6];
    logic [2:0]  exp_f;
    int          exp_lat, lat;
    va = '{16'h0000, 16'h0001, 16'd29, 16'h8000, 16'h8000, 16'hFFFF};
    vb = '{16'h0000, 16'h0000, 16'd30, 16'h0001, 16'h0001, 16'h0001};
    vs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      model(va[i], vb[i], vs[i], exp_f, exp_lat);
      launch(va[i], vb[i], vs[i]);
      wait_done(lat);
      total_cnt++;
      if (lat !== exp_lat) $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if ({bus.agreat, bus.bgreat, bus.equal} !== exp_f)
        $display("FAIL dir%0d_flags: got %b want %b", i, {bus.agreat, bus.bgreat, bus.equal}, exp_f);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({bus.done, bus.busy, bus.agreat, bus.bgreat, bus.equal} !== {2'b00, exp_f})
        $display("FAIL dir%0d_after_done: got %b want %b", i,
                 {bus.done, bus.busy, bus.agreat, bus.bgreat, bus.equal}, {2'b00, exp_f});
      else pass_cnt++;
    end
  endtask

  task automatic test_ignore_busy;
    int ndone, first;
    ndone = 0;
    first = -1;
    launch(16'h1234, 16'h1230, 1'b0);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        ndone++;
        if (first < 0) first = k;
      end
      if (k == 1) bus.start = 1'b0;
      if (k == 2) begin
        bus.start = 1'b1;
        bus.a = 16'h0000;
        bus.b = 16'h0000;
      end
      if (k == 3) bus.start = 1'b0;
    end
    total_cnt++;
    if (ndone !== 1) $display("FAIL ignore_done_count: got %0d want 1", ndone);
    else pass_cnt++;
    total_cnt++;
    if (first !== 5) $display("FAIL ignore_latency: got %0d want 5", first);
    else pass_cnt++;
    total_cnt++;
    if ({bus.busy, bus.agreat, bus.bgreat, bus.equal} !== 4'b0100)
      $display("FAIL ignore_flags: got %b want 0100", {bus.busy, bus.agreat, bus.bgreat, bus.equal});
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [15:0] av, bv;
    logic        sm;
    logic [2:0]  exp_f;
    int          exp_lat, lat, kind;
    for (int i = 0; i < 40; i++) begin
      av   = 16'($urandom);
      kind = $urandom_range(0, 3);
      if (kind == 0)      bv = av;
      else if (kind == 1) bv = av ^ (16'h1 << $urandom_range(0, 15));
      else                bv = 16'($urandom);
      sm = 1'($urandom);
      model(av, bv, sm, exp_f, exp_lat);
      launch(av, bv, sm);
      wait_done(lat);
      total_cnt++;
      if (lat !== exp_lat)
        $display("FAIL rnd%0d_latency: a=%h b=%h s=%b got %0d want %0d", i, av, bv, sm, lat, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if ({bus.agreat, bus.bgreat, bus.equal} !== exp_f)
        $display("FAIL rnd%0d_flags: a=%h b=%h s=%b got %b want %b", i, av, bv, sm,
                 {bus.agreat, bus.bgreat, bus.equal}, exp_f);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({bus.done, bus.busy, bus.agreat, bus.bgreat, bus.equal} !== {2'b00, exp_f})
        $display("FAIL rnd%0d_hold: got %b want %b", i,
                 {bus.done, bus.busy, bus.agreat, bus.bgreat, bus.equal}, {2'b00, exp_f});
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    int   dq[$];
    logic prev_done;
    int   j;
    prev_done = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = 16'hFFFF;
    bus.b = 16'hFFFF;
    bus.signed_mode = 1'($urandom);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dq.push_back(k);
      if (bus.done === 1'b1 || prev_done) begin
        total_cnt++;
        if ({bus.agreat, bus.bgreat, bus.equal} !== 3'b001)
          $display("FAIL b2b_equal_held_k%0d: got %b want 001", k, {bus.agreat, bus.bgreat, bus.equal});
        else pass_cnt++;
      end
      prev_done = bus.done;
    end
    bus.start = 1'b0;
    j = 0;
    do begin
      @(negedge clk);
      j++;
    end while (bus.busy && j < 20);
    total_cnt++;
    if (bus.busy !== 1'b0) $display("FAIL b2b_drain: busy=%b want 0", bus.busy);
    else pass_cnt++;
    total_cnt++;
    if (dq.size() !== 5) $display("FAIL b2b_pulse_count: got %0d want 5", dq.size());
    else pass_cnt++;
    if (dq.size() > 0) begin
      total_cnt++;
      if (dq[0] !== NSLICE + 1) $display("FAIL b2b_first: got %0d want %0d", dq[0], NSLICE + 1);
      else pass_cnt++;
    end
    for (int i = 1; i < dq.size(); i++) begin
      total_cnt++;
      if (dq[i] - dq[i-1] !== NSLICE + 2)
        $display("FAIL b2b_period%0d: got %0d want %0d", i, dq[i] - dq[i-1], NSLICE + 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_run;
    int ndone, lat;
    ndone = 0;
    launch(16'd30, 16'd31, 1'b0);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (bus.busy !== 1'b1) $display("FAIL midrst_running: busy=%b want 1", bus.busy);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.busy, bus.done, bus.agreat, bus.bgreat, bus.equal} !== 5'b00000)
      $display("FAIL midrst_async_clear: got %b want 00000",
               {bus.busy, bus.done, bus.agreat, bus.bgreat, bus.equal});
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) ndone++;
      if (k == 2) rst_n = 1'b1;
    end
    total_cnt++;
    if (ndone !== 0) $display("FAIL midrst_no_done: got %0d want 0", ndone);
    else pass_cnt++;
    launch(16'd31, 16'd30, 1'b0);
    wait_done(lat);
    total_cnt++;
    if (lat !== NSLICE + 1) $display("FAIL midrst_fresh_latency: got %0d want %0d", lat, NSLICE + 1);
    else pass_cnt++;
    total_cnt++;
    if ({bus.agreat, bus.bgreat, bus.equal} !== 3'b100)
      $display("FAIL midrst_fresh_flags: got %b want 100", {bus.agreat, bus.bgreat, bus.equal});
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_directed();
    test_ignore_busy();
    test_random();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
